data_mem_pipe: RTL and testbench
================================

# data_mem_pipe

Parametrised, multi-cycle data memory for the MEM stage of the 5-stage pipeline. It generalises the single-word, zero-latency data memory in three ways:
- byte, halfword and word loads and stores, with load sign or zero extension;
- a configurable access latency, with a `stall` output that holds the pipeline front end while an access is in flight;
- optional misalignment detection.

The registered read data feeds the WB-stage result mux directly.

## Interface
Parameters:
- `DEPTH_LOG2`, 8, log2 of the number of 32-bit words.
- `LATENCY`, 1, cycles an access occupies the memory (≥1).

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: access request from the MEM stage this cycle.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: access size. 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `sign_ext` in 1: for loads, 1 = sign-extend, 0 = zero-extend.
- `Adr` in 32: byte address.
- `WD` in 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `RD` out 32: load result, extended to 32 bits.
- `rvalid` out 1: one-cycle pulse; `RD` is valid in this cycle.
- `stall` out 1: hold MEM and all earlier stages this cycle.
- `misalign` out 1: access rejected as misaligned; only exists when the error feature is compiled in.

## Operation
- Storage is 2^DEPTH_LOG2 words of 32 bits, little-endian byte lanes.
- Word index is `Adr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so accesses wrap.
- FSM states are IDLE and BUSY.
- IDLE, `req`=1, access legal:
  - latch `we`, `size`, `sign_ext`, `Adr` and `WD`;
  - load the countdown with `LATENCY-1`;
  - go to BUSY if `LATENCY`>1, otherwise complete in this cycle.
- BUSY: decrement the countdown each cycle. When it reaches 0 (the final cycle), complete and return to IDLE.
- A new `req` in the completion cycle (the pipeline has advanced) is accepted in the next IDLE cycle.
- Completion (at the final-cycle edge):
  - Store: write only the selected lanes.
    - byte: lane `Adr[1:0]`, taking `WD[7:0]`;
    - halfword: lanes {`Adr[1]`,0} and {`Adr[1]`,1}, taking `WD[15:0]`;
    - word: all four lanes.
  - Load: select the byte or halfword, extend it per `sign_ext`, register it into `RD`, and pulse `rvalid` in the next cycle.
  - Store completion does not pulse `rvalid`. `RD` keeps its previous value.
- `req` in BUSY is ignored. The latched operands are used, so inputs may change while `stall`=1.
- Ordering is strict: a load accepted after a store completes sees the stored data.
- `stall` is combinational: 1 in the acceptance cycle and every BUSY cycle except the final one. With `LATENCY`=1, `stall` is never 1.
- Reset (any cycle, including mid-access):
  - FSM returns to IDLE; a pending store is dropped;
  - `RD`=0, `rvalid`=0, `stall`=0, `misalign`=0;
  - memory contents are unchanged.

## Timing
- Acceptance at cycle c0.
- Store data is written at the rising edge ending cycle c0+`LATENCY`-1.
- Load: `rvalid`=1 and `RD` are valid in cycle c0+`LATENCY`.
- `stall` is high in cycles c0 through c0+`LATENCY`-2 (`LATENCY`-1 cycles in total).
- Back-to-back accesses: sustained throughput is one access per `LATENCY` cycles.
- `misalign` is combinational, valid in the request cycle only.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- Defined:
  - a halfword with `Adr[0]`=1, or a word with `Adr[1:0]`≠00, is misaligned;
  - the misaligned request is not accepted: `misalign`=1 in that cycle, no stall, no write, no `rvalid`, FSM stays in IDLE.
- Undefined:
  - the `misalign` port is absent;
  - halfword accesses force `Adr[0]`=0 and word accesses force `Adr[1:0]`=00, then proceed normally.

## Test plan
- `LATENCY`=1: store word 0xDEADBEEF at 0x10, then load word from 0x10 → `rvalid` one cycle after the load request, `RD`=0xDEADBEEF, `stall` never 1.
- Lane writes: store byte 0x80 at 0x13, then load byte at 0x13 with `sign_ext`=1 → `RD`=0xFFFFFF80; with `sign_ext`=0 → `RD`=0x00000080; load word 0x10 → `RD`=0x80ADBEEF.
- `LATENCY`=3: load at c0 → `stall` high in c0 and c1, low in c2, `rvalid` in c3. Changing `Adr` in c1 does not affect the result.
- Reset in c1 of a `LATENCY`=3 store to 0x20 → no write occurs (0x20 keeps its old value), `stall`=0 and `rvalid`=0 in the cycle after reset.
- With `DMEM_ALIGN_CHECK_EN`: halfword store at 0x21 → `misalign`=1, `stall`=0, memory unchanged. Without the macro: the same store writes lanes 0–1 of word 0x20.
- Wrap: with `DEPTH_LOG2`=8, a store at 0x400 followed by a load at 0x000 returns the stored value.

Source files
------------

// File: rtl/data_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : data_mem_pipe_if
// Brief  : MEM-stage request/response bundle for data_mem_pipe.
//          misalign exists only when DMEM_ALIGN_CHECK_EN is defined.
// Rev    : 1.0
// ============================================================================
interface data_mem_pipe_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] Adr;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        rvalid;
  logic        stall;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  modport master (
    output req, we, size, sign_ext, Adr, WD,
    input  RD, rvalid, stall
`ifdef DMEM_ALIGN_CHECK_EN
    , input misalign
`endif
  );

  modport slave (
    input  req, we, size, sign_ext, Adr, WD,
    output RD, rvalid, stall
`ifdef DMEM_ALIGN_CHECK_EN
    , output misalign
`endif
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module : data_mem_pipe
// Brief  : Multi-cycle byte/halfword/word data memory for the MEM stage.
//          Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
// Rev    : 1.0
// ============================================================================
module data_mem_pipe #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 1
) (
  input  wire logic      clk,
  input  wire logic      reset,
  data_mem_pipe_if.slave bus
);
  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam int c_AW    = DEPTH_LOG2 + 2;
  localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_count;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_signExt;
  logic [c_AW-1:0]    r_adr;
  logic [31:0]        r_wd;
  logic [31:0]        r_rd;
  logic               r_rvalid;
  logic [31:0]        r_mem [c_DEPTH];

  logic               w_misalign;
  logic               w_accept;
  logic               w_lastBusy;
  logic               w_complete;
  logic [c_AW-1:0]    w_adrNorm;
  logic               w_opWe;
  logic [1:0]         w_opSize;
  logic               w_opSignExt;
  logic [c_AW-1:0]    w_opAdr;
  logic [31:0]        w_opWd;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]        w_memWord;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_loadData;
  logic [3:0]         w_wrMask;
  logic [31:0]        w_wrData;
  logic               w_unusedAdr;

  // Address bits above the array wrap away.
  assign w_unusedAdr = ^bus.Adr[31:c_AW];

  always_comb begin
    w_adrNorm = bus.Adr[c_AW-1:0];
    if (bus.size == 2'b01) begin
      w_adrNorm[0] = 1'b0;
    end else if (bus.size[1]) begin
      w_adrNorm[1:0] = 2'b00;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = (r_state == IDLE) && bus.req && !reset &&
                      (((bus.size == 2'b01) && bus.Adr[0]) ||
                       (bus.size[1] && (bus.Adr[1:0] != 2'b00)));
  assign bus.misalign = w_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept   = (r_state == IDLE) && bus.req && !w_misalign && !reset;
  assign w_lastBusy = (r_state == BUSY) && (r_count == c_CNT_ONE);
  assign w_complete = ((w_accept && (LATENCY == 1)) || w_lastBusy) && !reset;
  assign bus.stall  = !reset && ((w_accept && (LATENCY > 1)) ||
                                 ((r_state == BUSY) && !w_lastBusy));

  // Single-cycle accesses complete on the live inputs; longer ones on the latch.
  assign w_opWe      = (r_state == IDLE) ? bus.we       : r_we;
  assign w_opSize    = (r_state == IDLE) ? bus.size     : r_size;
  assign w_opSignExt = (r_state == IDLE) ? bus.sign_ext : r_signExt;
  assign w_opAdr     = (r_state == IDLE) ? w_adrNorm    : r_adr;
  assign w_opWd      = (r_state == IDLE) ? bus.WD       : r_wd;

  assign w_idx     = w_opAdr[c_AW-1:2];
  assign w_memWord = r_mem[w_idx];
  assign w_byte    = w_memWord[{w_opAdr[1:0], 3'b000} +: 8];
  assign w_half    = w_opAdr[1] ? w_memWord[31:16] : w_memWord[15:0];

  always_comb begin
    w_loadData = w_memWord;
    w_wrMask   = 4'b1111;
    w_wrData   = w_opWd;
    case (w_opSize)
      2'b00: begin
        w_loadData = {{24{w_opSignExt & w_byte[7]}}, w_byte};
        w_wrMask   = 4'b0001 << w_opAdr[1:0];
        w_wrData   = {4{w_opWd[7:0]}};
      end
      2'b01: begin
        w_loadData = {{16{w_opSignExt & w_half[15]}}, w_half};
        w_wrMask   = w_opAdr[1] ? 4'b1100 : 4'b0011;
        w_wrData   = {2{w_opWd[15:0]}};
      end
      default: begin
        w_loadData = w_memWord;
        w_wrMask   = 4'b1111;
        w_wrData   = w_opWd;
      end
    endcase
  end

  // Storage has no reset so contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (w_complete && w_opWe) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wrMask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wrData[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_rd     <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_complete && !w_opWe) begin
        r_rd     <= w_loadData;
        r_rvalid <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we      <= bus.we;
            r_size    <= bus.size;
            r_signExt <= bus.sign_ext;
            r_adr     <= w_adrNorm;
            r_wd      <= bus.WD;
            r_count   <= c_CNT_LOAD;
            if (LATENCY > 1) begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_count <= r_count - c_CNT_ONE;
          if (w_lastBusy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.RD     = r_rd;
  assign bus.rvalid = r_rvalid;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_pipe
// Brief  : Scoreboard bench driving a LATENCY=1 and a LATENCY=3 instance.
// Rev    : 1.0
// ============================================================================
module tb_data_mem_pipe;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   started;
  logic [31:0] q1[$];
  logic [31:0] q3[$];

  data_mem_pipe_if bus1 ();
  data_mem_pipe_if bus3 ();

  data_mem_pipe #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  data_mem_pipe #(.DEPTH_LOG2(8), .LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic req, input logic we, input logic [1:0] size,
                       input logic sext, input logic [31:0] adr, input logic [31:0] wd);
    if (d == 1) begin
      bus1.req = req; bus1.we = we; bus1.size = size;
      bus1.sign_ext = sext; bus1.Adr = adr; bus1.WD = wd;
    end else begin
      bus3.req = req; bus3.we = we; bus3.size = size;
      bus3.sign_ext = sext; bus3.Adr = adr; bus3.WD = wd;
    end
  endtask

  function automatic logic getStall(input int d);
    return (d == 1) ? bus1.stall : bus3.stall;
  endfunction

  function automatic logic getRvalid(input int d);
    return (d == 1) ? bus1.rvalid : bus3.rvalid;
  endfunction

  // One access; inputs are scrambled after acceptance to prove operands are latched.
  task automatic doAccess(input int d, input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] adr, input logic [31:0] wd, input logic [31:0] exp);
    int   stallCycles;
    bit   done;
    logic st;
    if (!we) begin
      if (d == 1) q1.push_back(exp);
      else        q3.push_back(exp);
    end
    drive(d, 1'b1, we, size, sext, adr, wd);
    stallCycles = 0;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      st = getStall(d);
      @(posedge clk);
      #1;
      if (i == 0) drive(d, 1'b0, 1'b0, 2'b10, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A5A);
      if (st) stallCycles++;
      else    done = 1'b1;
    end
    checkVal($sformatf("stallCycles%0d", d), done ? stallCycles : 99, d - 1);
    @(negedge clk);
    checkVal($sformatf("rvalidAt%0d", d), {31'b0, getRvalid(d)}, {31'b0, !we});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (bus1.rvalid) begin
        if (q1.size() == 0) checkVal("rvalidUnexp1", 32'd1, 32'd0);
        else                checkVal("load1", bus1.RD, q1.pop_front());
      end
      if (bus3.rvalid) begin
        if (q3.size() == 0) checkVal("rvalidUnexp3", 32'd1, 32'd0);
        else                checkVal("load3", bus3.RD, q3.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    started = 1'b0;
    drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkVal("rstRD1", bus1.RD, 32'h0);
    checkVal("rstRvalid1", {31'b0, bus1.rvalid}, 32'h0);
    checkVal("rstStall1", {31'b0, bus1.stall}, 32'h0);
    checkVal("rstRD3", bus3.RD, 32'h0);
    checkVal("rstRvalid3", {31'b0, bus3.rvalid}, 32'h0);
    checkVal("rstStall3", {31'b0, bus3.stall}, 32'h0);
    started = 1'b1;
    @(posedge clk);
    #1;

    // LATENCY=1 word and lane accesses
    doAccess(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0);
    doAccess(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    doAccess(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5680, 32'h0);
    checkVal("rdHoldAfterStore", bus1.RD, 32'hDEAD_BEEF);
    doAccess(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFF_FF80);
    doAccess(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_0080);
    doAccess(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80AD_BEEF);
    doAccess(1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF_80AD);
    doAccess(1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000_BEEF);

    // Misaligned halfword store
    doAccess(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111, 32'h0);
    drive(1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_ABCD);
    @(negedge clk);
`ifdef DMEM_ALIGN_CHECK_EN
    checkVal("misalign", {31'b0, bus1.misalign}, 32'h1);
`endif
    checkVal("misStall", {31'b0, bus1.stall}, 32'h0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
`ifdef DMEM_ALIGN_CHECK_EN
    doAccess(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1111_1111);
`else
    doAccess(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1111_ABCD);
`endif

    // Address wrap
    doAccess(1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h0BAD_F00D, 32'h0);
    doAccess(1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h0BAD_F00D);

    // LATENCY=3 accesses
    doAccess(3, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0);
    doAccess(3, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D);
    doAccess(3, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'h0000_00F0);
    doAccess(3, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111, 32'h0);

    // Reset in c1 of a LATENCY=3 store drops the write
    drive(3, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h2222_2222);
    @(posedge clk);
    #1;
    drive(3, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkVal("midRstStall", {31'b0, bus3.stall}, 32'h0);
    checkVal("midRstRvalid", {31'b0, bus3.rvalid}, 32'h0);
    checkVal("midRstRD", bus3.RD, 32'h0);
    @(posedge clk);
    #1;
    doAccess(3, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1111_1111);
    doAccess(3, 1'b1, 2'b01, 1'b0, 32'h26, 32'h0000_9876, 32'h0);
    doAccess(3, 1'b0, 2'b01, 1'b1, 32'h26, 32'h0, 32'hFFFF_9876);

    repeat (4) @(posedge clk);
    checkVal("q1Drained", q1.size(), 32'd0);
    checkVal("q3Drained", q3.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
